// File: rtl/sad_disparity_stream_pkg.sv
// Shared types and width helpers for the streaming SAD disparity engine.
// The optional uniqueness check is enabled by defining SAD_DISP_UNIQUENESS_EN.
package disparity_pkg;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    SEARCH = 2'd1,
    FLUSH  = 2'd2,
    OUTPUT = 2'd3
  } disp_state_e;

  localparam int COST_MAX_W = 32;
  localparam logic [COST_MAX_W-1:0] COST_ALL_ONES = {COST_MAX_W{1'b1}};

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int disp_w(input int max_disp);
    return (clog2(max_disp) < 1) ? 1 : clog2(max_disp);
  endfunction

  function automatic int cost_w(input int pix_w, input int block);
    return pix_w + clog2(block * block);
  endfunction

endpackage

// File: rtl/sad_disparity_stream_cost.sv
// Sum of absolute differences over one BLOCK x BLOCK window pair, registered once.
module sad_window_cost import disparity_pkg::*; #(
  parameter int PIX_W = 8,
  parameter int BLOCK = 5
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [BLOCK*BLOCK*PIX_W-1:0]         i_left_win,
  input  logic [BLOCK*BLOCK*PIX_W-1:0]         i_right_win,
  output logic [cost_w(PIX_W, BLOCK)-1:0]      o_cost
);

  localparam int N  = BLOCK * BLOCK;
  localparam int CW = cost_w(PIX_W, BLOCK);

  logic [PIX_W-1:0] w_ad [N];
  logic [CW-1:0]    w_sum;
  logic [CW-1:0]    r_cost;

  for (genvar gi = 0; gi < N; gi++) begin : g_absdiff
    logic [PIX_W-1:0] w_a;
    logic [PIX_W-1:0] w_b;
    assign w_a       = i_left_win[gi*PIX_W +: PIX_W];
    assign w_b       = i_right_win[gi*PIX_W +: PIX_W];
    assign w_ad[gi]  = (w_a > w_b) ? (w_a - w_b) : (w_b - w_a);
  end

  // accumulate the absolute differences at full cost width
  always_comb begin
    w_sum = {CW{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_sum = w_sum + CW'(w_ad[i]);
    end
  end

  // cost pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cost <= {CW{1'b0}};
    else       r_cost <= w_sum;
  end

  assign o_cost = r_cost;

endmodule

// File: rtl/sad_disparity_stream.sv
// Streaming block-matching disparity: line buffers, sliding windows, FSM and argmin.
// Define SAD_DISP_UNIQUENESS_EN to flag results whose best match is not unique.
module sad_disparity_stream import disparity_pkg::*; #(
  parameter int PIX_W      = 8,
  parameter int IMG_W      = 450,
  parameter int IMG_H      = 375,
  parameter int BLOCK      = 5,
  parameter int MAX_DISP   = 25,
  parameter int UNIQ_SHIFT = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic                              s_sof,
  input  logic [PIX_W-1:0]                  s_left,
  input  logic [PIX_W-1:0]                  s_right,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [disp_w(MAX_DISP)-1:0]       m_disp,
  output logic [cost_w(PIX_W, BLOCK)-1:0]   m_cost,
  output logic                              m_border,
  output logic                              m_eof
);

  localparam int DW = disp_w(MAX_DISP);
  localparam int CW = cost_w(PIX_W, BLOCK);
  localparam int RW = BLOCK + MAX_DISP - 1;
  localparam int LB = BLOCK - 1;
  localparam int XW = (clog2(IMG_W) < 1) ? 1 : clog2(IMG_W);
  localparam int YW = (clog2(IMG_H) < 1) ? 1 : clog2(IMG_H);
  localparam int FW = BLOCK * BLOCK * PIX_W;
  localparam logic [CW-1:0] COST_ONES = COST_ALL_ONES[CW-1:0];

  if ((BLOCK % 2) == 0 || BLOCK < 3 || MAX_DISP < 1 || UNIQ_SHIFT < 0) begin : g_bad_cfg
    $error("sad_disparity_stream: unsupported parameter set");
  end

  logic [PIX_W-1:0] r_llb  [LB][IMG_W];
  logic [PIX_W-1:0] r_rlb  [LB][IMG_W];
  logic [PIX_W-1:0] r_lwin [BLOCK][BLOCK];
  logic [PIX_W-1:0] r_rwin [BLOCK][RW];
  logic [PIX_W-1:0] w_lcol [BLOCK];
  logic [PIX_W-1:0] w_rcol [BLOCK];
  logic [FW-1:0]    w_lflat;
  logic [FW-1:0]    w_rslice [MAX_DISP];

  disp_state_e      r_state, w_next;
  logic [XW-1:0]    r_col, w_col, w_col_nxt;
  logic [YW-1:0]    r_row, w_row, w_row_nxt;
  logic [DW-1:0]    r_d, r_dmax, r_cost_d, r_best_d, w_dmax, w_upd_d, w_fin_disp;
  logic [CW-1:0]    w_cost, r_best_cost, w_upd_cost;
  logic             r_cost_vld, r_peof, w_accept, w_border, w_eof, w_take, w_fin_border;
  logic             r_s_ready, r_m_valid, w_s_ready_nxt, w_m_valid_nxt;
  logic [DW-1:0]    r_m_disp;
  logic [CW-1:0]    r_m_cost;
  logic             r_m_border, r_m_eof;

  assign w_accept  = (r_state == ACCEPT) && s_valid;
  assign w_col     = s_sof ? {XW{1'b0}} : r_col;
  assign w_row     = s_sof ? {YW{1'b0}} : r_row;
  assign w_col_nxt = (w_col == XW'(IMG_W - 1)) ? {XW{1'b0}} : (w_col + XW'(1'b1));
  assign w_row_nxt = (w_col != XW'(IMG_W - 1)) ? w_row :
                     ((w_row == YW'(IMG_H - 1)) ? {YW{1'b0}} : (w_row + YW'(1'b1)));
  assign w_border  = (w_row < YW'(BLOCK - 1)) || (w_col < XW'(BLOCK - 1));
  assign w_eof     = (w_col == XW'(IMG_W - 1)) && (w_row == YW'(IMG_H - 1));
  assign w_dmax    = ((int'(w_col) - (BLOCK - 1)) >= (MAX_DISP - 1)) ? DW'(MAX_DISP - 1)
                                                                     : DW'(int'(w_col) - (BLOCK - 1));

  // Row 0 of a column vector is the oldest line; the last row is the incoming pixel.
  for (genvar gr = 0; gr < LB; gr++) begin : g_col_rd
    assign w_lcol[gr] = r_llb[gr][w_col];
    assign w_rcol[gr] = r_rlb[gr][w_col];
  end
  assign w_lcol[LB] = s_left;
  assign w_rcol[LB] = s_right;

  // Right column c holds x = col-(RW-1)+c, so disparity d starts at column MAX_DISP-1-d.
  for (genvar gr = 0; gr < BLOCK; gr++) begin : g_flat_r
    for (genvar gk = 0; gk < BLOCK; gk++) begin : g_flat_k
      assign w_lflat[(gr*BLOCK+gk)*PIX_W +: PIX_W] = r_lwin[gr][gk];
      for (genvar gd = 0; gd < MAX_DISP; gd++) begin : g_flat_d
        assign w_rslice[gd][(gr*BLOCK+gk)*PIX_W +: PIX_W] = r_rwin[gr][MAX_DISP-1-gd+gk];
      end
    end
  end

  sad_window_cost #(.PIX_W(PIX_W), .BLOCK(BLOCK)) u_cost (
    .clk         (clk),
    .reset       (reset),
    .i_left_win  (w_lflat),
    .i_right_win (w_rslice[r_d]),
    .o_cost      (w_cost)
  );

  // line buffers and windows shift on every accepted pair; contents need no reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int r = 0; r < BLOCK; r++) begin
        for (int c = 0; c < BLOCK - 1; c++) r_lwin[r][c] <= r_lwin[r][c+1];
        for (int c = 0; c < RW - 1; c++)    r_rwin[r][c] <= r_rwin[r][c+1];
        r_lwin[r][BLOCK-1] <= w_lcol[r];
        r_rwin[r][RW-1]    <= w_rcol[r];
      end
      for (int j = 0; j < LB; j++) begin
        r_llb[j][w_col] <= w_lcol[j+1];
        r_rlb[j][w_col] <= w_rcol[j+1];
      end
    end
  end

  // Strictly-less keeps the smaller disparity on ties.
  assign w_take     = r_cost_vld && (w_cost < r_best_cost);
  assign w_upd_cost = w_take ? w_cost   : r_best_cost;
  assign w_upd_d    = w_take ? r_cost_d : r_best_d;

`ifdef SAD_DISP_UNIQUENESS_EN
  logic [CW-1:0] r_costs [MAX_DISP];
  logic [CW-1:0] w_sec_cost;
  logic          w_sec_vld;
  logic          w_not_unique;

  // keep every candidate cost of the current pixel for the second-best scan
  always_ff @(posedge clk) begin
    if (r_cost_vld) r_costs[r_cost_d] <= w_cost;
  end

  // second-best over candidates at least two disparities away from the winner
  always_comb begin
    w_sec_vld  = 1'b0;
    w_sec_cost = COST_ONES;
    for (int i = 0; i < MAX_DISP; i++) begin
      if ((i <= int'(r_dmax)) &&
          ((i > int'(w_upd_d) + 1) || (i + 1 < int'(w_upd_d))) &&
          (!w_sec_vld || (((i == int'(r_cost_d)) ? w_cost : r_costs[i]) < w_sec_cost))) begin
        w_sec_vld  = 1'b1;
        w_sec_cost = (i == int'(r_cost_d)) ? w_cost : r_costs[i];
      end else begin
        w_sec_vld  = w_sec_vld;
      end
    end
  end

  assign w_not_unique = !w_sec_vld || ((w_sec_cost - w_upd_cost) < (w_upd_cost >> UNIQ_SHIFT));
  assign w_fin_border = w_not_unique;
  assign w_fin_disp   = w_not_unique ? {DW{1'b0}} : w_upd_d;
`else
  assign w_fin_border = 1'b0;
  assign w_fin_disp   = w_upd_d;
`endif

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ACCEPT;
    else       r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ACCEPT:  if (s_valid) w_next = w_border ? OUTPUT : SEARCH;
               else         w_next = ACCEPT;
      SEARCH:  if (r_d == r_dmax) w_next = FLUSH;
               else               w_next = SEARCH;
      FLUSH:   w_next = OUTPUT;
      OUTPUT:  if (m_ready) w_next = ACCEPT;
               else         w_next = OUTPUT;
      default: w_next = ACCEPT;
    endcase
  end

  // handshake outputs, registered from the next state
  always_comb begin
    w_s_ready_nxt = 1'b0;
    w_m_valid_nxt = 1'b0;
    case (w_next)
      ACCEPT:  w_s_ready_nxt = 1'b1;
      OUTPUT:  w_m_valid_nxt = 1'b1;
      default: w_s_ready_nxt = 1'b0;
    endcase
  end

  // counters, search index, argmin and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col       <= {XW{1'b0}};
      r_row       <= {YW{1'b0}};
      r_d         <= {DW{1'b0}};
      r_dmax      <= {DW{1'b0}};
      r_cost_d    <= {DW{1'b0}};
      r_cost_vld  <= 1'b0;
      r_best_d    <= {DW{1'b0}};
      r_best_cost <= COST_ONES;
      r_peof      <= 1'b0;
      r_s_ready   <= 1'b1;
      r_m_valid   <= 1'b0;
      r_m_disp    <= {DW{1'b0}};
      r_m_cost    <= {CW{1'b0}};
      r_m_border  <= 1'b0;
      r_m_eof     <= 1'b0;
    end else begin
      r_s_ready  <= w_s_ready_nxt;
      r_m_valid  <= w_m_valid_nxt;
      r_cost_vld <= (r_state == SEARCH);
      r_cost_d   <= r_d;
      case (r_state)
        ACCEPT: if (s_valid) begin
          r_col       <= w_col_nxt;
          r_row       <= w_row_nxt;
          r_d         <= {DW{1'b0}};
          r_dmax      <= w_dmax;
          r_best_d    <= {DW{1'b0}};
          r_best_cost <= COST_ONES;
          r_peof      <= w_eof;
          if (w_border) begin
            r_m_disp   <= {DW{1'b0}};
            r_m_cost   <= COST_ONES;
            r_m_border <= 1'b1;
            r_m_eof    <= w_eof;
          end
        end
        SEARCH: begin
          r_d         <= r_d + DW'(1'b1);
          r_best_d    <= w_upd_d;
          r_best_cost <= w_upd_cost;
        end
        FLUSH: begin
          r_m_disp   <= w_fin_disp;
          r_m_cost   <= w_upd_cost;
          r_m_border <= w_fin_border;
          r_m_eof    <= r_peof;
        end
        default: r_d <= r_d;
      endcase
    end
  end

  assign s_ready  = r_s_ready;
  assign m_valid  = r_m_valid;
  assign m_disp   = r_m_disp;
  assign m_cost   = r_m_cost;
  assign m_border = r_m_border;
  assign m_eof    = r_m_eof;

endmodule

// File: tb/tb_sad_disparity_stream.sv
// Directed bench for sad_disparity_stream on a 16x8 image, BLOCK=3, MAX_DISP=4.
// Expectations follow SAD_DISP_UNIQUENESS_EN when the bench is built with it.
module tb_sad_disparity_stream;

  localparam logic [31:0] COST_ONES = 32'hFFF;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid, s_sof, s_ready;
  logic [7:0] s_left, s_right;
  logic       m_valid, m_ready, m_border, m_eof;
  logic [1:0] m_disp;
  logic [11:0] m_cost;

  int tests_run = 0;
  int tests_failed = 0;

  sad_disparity_stream #(
    .PIX_W(8), .IMG_W(16), .IMG_H(8), .BLOCK(3), .MAX_DISP(4), .UNIQ_SHIFT(3)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_left(s_left), .s_right(s_right),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_disp(m_disp), .m_cost(m_cost), .m_border(m_border), .m_eof(m_eof)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int x, input int y,
                           input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s at (%0d,%0d): got 0x%0h expected 0x%0h", tag, x, y, got, exp);
    end
  endtask

  function automatic logic [7:0] tex(input int x, input int y);
    int v;
    v = (x * 73 + y * 151 + x * x * 17) ^ (x * y * 29);
    return v[7:0] ^ 8'h5A;
  endfunction

  task automatic send_pix(input int pat, input int x, input int y);
    int g;
    g = 0;
    while (!s_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check_val("s_ready", x, y, 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_sof   = (x == 0 && y == 0);
    s_left  = (pat == 0) ? 8'h80 : tex(x, y);
    s_right = (pat == 0) ? 8'h80 : tex(x + 2, y);
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic get_result(input int pat, input int x, input int y, input bit hold);
    int lat, exp_lat, dmax;
    bit wb, kd, kc;
    logic [31:0] eb, ed, ec;
    logic [1:0]  cap_d;
    logic [11:0] cap_c;
    lat = 1;
    while (!m_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    wb = (x < 2 || y < 2);
    dmax = (x - 2 > 3) ? 3 : x - 2;
    exp_lat = wb ? 1 : dmax + 3;
    kd = 1'b1; kc = 1'b1;
    eb = 32'd0; ed = 32'd0; ec = 32'd0;
    if (wb) begin
      eb = 32'd1; ec = COST_ONES;
    end else if (pat == 0) begin
`ifdef SAD_DISP_UNIQUENESS_EN
      eb = (x < 4) ? 32'd1 : 32'd0;
`endif
    end else begin
`ifdef SAD_DISP_UNIQUENESS_EN
      if (x < 4) begin eb = 32'd1; kc = 1'b0; end
      else       begin ed = 32'd2; end
`else
      kd = (x >= 4); kc = (x >= 4); ed = 32'd2;
`endif
    end
    check_val("m_valid", x, y, 32'(m_valid), 32'd1);
    check_val("latency", x, y, 32'(lat), 32'(exp_lat));
    check_val("m_border", x, y, 32'(m_border), eb);
    if (kd) check_val("m_disp", x, y, 32'(m_disp), ed);
    if (kc) check_val("m_cost", x, y, 32'(m_cost), ec);
    check_val("m_eof", x, y, 32'(m_eof), (x == 15 && y == 7) ? 32'd1 : 32'd0);
    if (hold) begin
      cap_d = m_disp;
      cap_c = m_cost;
      repeat (10) begin
        @(negedge clk);
        check_val("hold_valid", x, y, 32'(m_valid), 32'd1);
        check_val("hold_s_ready", x, y, 32'(s_ready), 32'd0);
        check_val("hold_disp", x, y, 32'(m_disp), 32'(cap_d));
        check_val("hold_cost", x, y, 32'(m_cost), 32'(cap_c));
      end
      m_ready = 1'b1;
    end
    @(negedge clk);
    check_val("consumed", x, y, 32'(m_valid), 32'd0);
  endtask

  task automatic run_frame(input int pat, input int hx, input int hy,
                           input int sx, input int sy);
    int nres;
    nres = 0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 16; x++) begin
        send_pix(pat, x, y);
        if (x == sx && y == sy) begin
          reset = 1'b1;
          @(negedge clk);
          check_val("rst_s_ready", x, y, 32'(s_ready), 32'd1);
          check_val("rst_m_valid", x, y, 32'(m_valid), 32'd0);
          check_val("rst_m_cost", x, y, 32'(m_cost), 32'd0);
          reset = 1'b0;
          @(negedge clk);
          return;
        end
        if (x == hx && y == hy) m_ready = 1'b0;
        get_result(pat, x, y, (x == hx && y == hy));
        nres++;
      end
    end
    check_val("result_count", pat, 0, 32'(nres), 32'd128);
    repeat (5) begin
      @(negedge clk);
      check_val("no_extra", pat, 0, 32'(m_valid), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_sof = 1'b0; m_ready = 1'b1;
    s_left = 8'h00; s_right = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("reset_s_ready", 0, 0, 32'(s_ready), 32'd1);
    check_val("reset_m_valid", 0, 0, 32'(m_valid), 32'd0);
    check_val("reset_m_disp", 0, 0, 32'(m_disp), 32'd0);
    check_val("reset_m_cost", 0, 0, 32'(m_cost), 32'd0);
    check_val("reset_m_border", 0, 0, 32'(m_border), 32'd0);
    check_val("reset_m_eof", 0, 0, 32'(m_eof), 32'd0);

    run_frame(0, 5, 3, -1, -1);
    run_frame(1, 1, 0, -1, -1);
    run_frame(1, -1, -1, 10, 4);
    run_frame(0, -1, -1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
